// File: rtl/cdb_arbiter.sv
// Round-robin arbiter placing one execution-unit result per cycle onto the registered CDB.
// Optional macro CDB_STATS_EN adds saturating per-requester grant and conflict counters.
module cdb_arbiter #(
    parameter int NREQ     = 3,
    parameter int ROB_BITS = 4,
    parameter int PTR_W    = 3
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     flush,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ROB_BITS-1:0] req_robid,
    input  logic [NREQ*32-1:0]       req_value,
    input  logic [NREQ-1:0]          req_taken,
    output logic [NREQ-1:0]          req_ready,
    output logic                     cdb_valid,
    output logic [ROB_BITS-1:0]      cdb_robid,
    output logic [31:0]              cdb_value,
    output logic                     cdb_taken
`ifdef CDB_STATS_EN
    ,
    output logic [NREQ*16-1:0]       stat_grants,
    output logic [15:0]              stat_conflict
`endif
);

    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                cdb_valid_q, cdb_valid_d;
    logic [ROB_BITS-1:0] cdb_robid_q, cdb_robid_d;
    logic [31:0]         cdb_value_q, cdb_value_d;
    logic                cdb_taken_q, cdb_taken_d;

    logic                hi_found, lo_found;
    logic [PTR_W-1:0]    hi_idx, lo_idx, grant_idx;
    logic                grant_found, grant_ok;
    logic [ROB_BITS-1:0] sel_robid;
    logic [31:0]         sel_value;
    logic                sel_taken;

    // Two passes: first valid index at or above the pointer, else first valid overall (wrap).
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!hi_found && req_valid[i] && (PTR_W'(i) >= rr_ptr_q)) begin
                hi_found = 1'b1;
                hi_idx   = PTR_W'(i);
            end
            if (!lo_found && req_valid[i]) begin
                lo_found = 1'b1;
                lo_idx   = PTR_W'(i);
            end
        end
        grant_found = lo_found;
        grant_idx   = hi_found ? hi_idx : lo_idx;
        grant_ok    = rst_in && rdy_in && !flush && grant_found;
    end

    always_comb begin
        req_ready = '0;
        sel_robid = '0;
        sel_value = '0;
        sel_taken = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (PTR_W'(i) == grant_idx) begin
                req_ready[i] = grant_ok;
                sel_robid    = req_robid[i*ROB_BITS +: ROB_BITS];
                sel_value    = req_value[i*32 +: 32];
                sel_taken    = req_taken[i];
            end
        end
    end

    // Flush wins over a stall; a stall freezes everything so the ROB sees the broadcast again.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = cdb_valid_q;
        cdb_robid_d = cdb_robid_q;
        cdb_value_d = cdb_value_q;
        cdb_taken_d = cdb_taken_q;
        if (flush) begin
            cdb_valid_d = 1'b0;
            rr_ptr_d    = '0;
        end else if (rdy_in) begin
            cdb_valid_d = grant_found;
            if (grant_found) begin
                cdb_robid_d = sel_robid;
                cdb_value_d = sel_value;
                cdb_taken_d = sel_taken;
                rr_ptr_d    = (grant_idx == PTR_W'(NREQ - 1)) ? '0 : grant_idx + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_robid_q <= '0;
            cdb_value_q <= '0;
            cdb_taken_q <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_robid_q <= cdb_robid_d;
            cdb_value_q <= cdb_value_d;
            cdb_taken_q <= cdb_taken_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_robid = cdb_robid_q;
    assign cdb_value = cdb_value_q;
    assign cdb_taken = cdb_taken_q;

`ifdef CDB_STATS_EN
    logic [15:0] stat_grants_q [NREQ];
    logic [15:0] stat_grants_d [NREQ];
    logic [15:0] stat_conflict_q, stat_conflict_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Counters survive flush; only reset clears them.
    always_comb begin
        stat_conflict_d = stat_conflict_q;
        if (rdy_in && ((req_valid & (req_valid - NREQ'(1))) != '0))
            stat_conflict_d = sat_inc(stat_conflict_q);
        for (int i = 0; i < NREQ; i++) begin
            stat_grants_d[i] = req_ready[i] ? sat_inc(stat_grants_q[i]) : stat_grants_q[i];
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            stat_conflict_q <= '0;
            for (int i = 0; i < NREQ; i++) stat_grants_q[i] <= '0;
        end else begin
            stat_conflict_q <= stat_conflict_d;
            for (int i = 0; i < NREQ; i++) stat_grants_q[i] <= stat_grants_d[i];
        end
    end

    always_comb begin
        stat_grants = '0;
        for (int i = 0; i < NREQ; i++) stat_grants[i*16 +: 16] = stat_grants_q[i];
    end
    assign stat_conflict = stat_conflict_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter (NREQ=3): vector table plus hand sequences for stall, flush and async reset.
module tb_cdb_arbiter;

    localparam int NREQ = 3;
    localparam int RB   = 4;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              rdy_in;
    logic              flush;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*RB-1:0] req_robid;
    logic [NREQ*32-1:0] req_value;
    logic [NREQ-1:0]   req_taken;
    logic [NREQ-1:0]   req_ready;
    logic              cdb_valid;
    logic [RB-1:0]     cdb_robid;
    logic [31:0]       cdb_value;
    logic              cdb_taken;
`ifdef CDB_STATS_EN
    logic [NREQ*16-1:0] stat_grants;
    logic [15:0]        stat_conflict;
`endif

    cdb_arbiter #(.NREQ(NREQ), .ROB_BITS(RB), .PTR_W(3)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .flush     (flush),
        .req_valid (req_valid),
        .req_robid (req_robid),
        .req_value (req_value),
        .req_taken (req_taken),
        .req_ready (req_ready),
        .cdb_valid (cdb_valid),
        .cdb_robid (cdb_robid),
        .cdb_value (cdb_value),
        .cdb_taken (cdb_taken)
`ifdef CDB_STATS_EN
        ,
        .stat_grants   (stat_grants),
        .stat_conflict (stat_conflict)
`endif
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [2:0] valid;
        logic       fl;
        logic       rdy;
        logic [2:0] ready;
    } vec_t;

    typedef struct {
        logic [RB-1:0] robid;
        logic [31:0]   value;
        logic          taken;
    } exp_t;

    vec_t tbl [15];
    exp_t sb_q [$];
    int   seq [NREQ];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic          m_valid = 1'b0;
    logic [RB-1:0] m_robid = '0;
    logic [31:0]   m_value = '0;
    logic          m_taken = 1'b0;

    // Each requester presents its seq-th result, advancing only after its own transfer.
    function automatic logic [RB-1:0] f_robid(input int i, input int s);
        return RB'((i * 5 + s * 3 + 5) & 15);
    endfunction
    function automatic logic [31:0] f_value(input int i, input int s);
        return 32'h1000 * 32'(i + 1) + 32'(s);
    endfunction
    function automatic logic f_taken(input int i, input int s);
        return 1'((i + s) & 1);
    endfunction

    task automatic drive_data();
        for (int i = 0; i < NREQ; i++) begin
            req_robid[i*RB +: RB] = f_robid(i, seq[i]);
            req_value[i*32 +: 32] = f_value(i, seq[i]);
            req_taken[i]          = f_taken(i, seq[i]);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic chk_cdb();
        chk("cdb_valid", 32'(cdb_valid), 32'(m_valid));
        chk("cdb_robid", 32'(cdb_robid), 32'(m_robid));
        chk("cdb_value", cdb_value, m_value);
        chk("cdb_taken", 32'(cdb_taken), 32'(m_taken));
    endtask

    task automatic do_cycle(input logic [2:0] valid, input logic fl, input logic rdy,
                            input logic [2:0] exp_ready);
        exp_t e;
        @(negedge clk_in);
        req_valid = valid;
        flush     = fl;
        rdy_in    = rdy;
        drive_data();
        #1;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        for (int i = 0; i < NREQ; i++) begin
            if (exp_ready[i]) begin
                e.robid = f_robid(i, seq[i]);
                e.value = f_value(i, seq[i]);
                e.taken = f_taken(i, seq[i]);
                sb_q.push_back(e);
                seq[i]++;
            end
        end
        @(posedge clk_in);
        #1;
        if (fl) begin
            m_valid = 1'b0;
        end else if (rdy) begin
            if (sb_q.size() > 0) begin
                e       = sb_q.pop_front();
                m_valid = 1'b1;
                m_robid = e.robid;
                m_value = e.value;
                m_taken = e.taken;
            end else begin
                m_valid = 1'b0;
            end
        end
        chk_cdb();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        // valid, flush, rdy, expected one-hot grant (pointer starts at 0)
        tbl[0]  = '{3'b010, 1'b0, 1'b1, 3'b010};
        tbl[1]  = '{3'b000, 1'b0, 1'b1, 3'b000};
        tbl[2]  = '{3'b011, 1'b0, 1'b1, 3'b001};
        tbl[3]  = '{3'b011, 1'b0, 1'b1, 3'b010};
        tbl[4]  = '{3'b111, 1'b0, 1'b1, 3'b100};
        tbl[5]  = '{3'b111, 1'b0, 1'b1, 3'b001};
        tbl[6]  = '{3'b111, 1'b0, 1'b1, 3'b010};
        tbl[7]  = '{3'b111, 1'b0, 1'b1, 3'b100};
        tbl[8]  = '{3'b100, 1'b0, 1'b1, 3'b100};
        tbl[9]  = '{3'b101, 1'b0, 1'b1, 3'b001};
        tbl[10] = '{3'b101, 1'b0, 1'b1, 3'b100};
        tbl[11] = '{3'b111, 1'b1, 1'b1, 3'b000};
        tbl[12] = '{3'b111, 1'b0, 1'b1, 3'b001};
        tbl[13] = '{3'b110, 1'b0, 1'b1, 3'b010};
        tbl[14] = '{3'b000, 1'b0, 1'b1, 3'b000};

        for (int i = 0; i < NREQ; i++) seq[i] = 0;

        rst_in    = 1'b0;
        rdy_in    = 1'b1;
        flush     = 1'b0;
        req_valid = 3'b111;
        drive_data();
        repeat (2) @(posedge clk_in);
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'h0);
        chk_cdb();
        @(negedge clk_in);
        req_valid = 3'b000;
        rst_in    = 1'b1;

        for (int v = 0; v < 15; v++) begin
            do_cycle(tbl[v].valid, tbl[v].fl, tbl[v].rdy, tbl[v].ready);
        end

        // Stall: a live broadcast must be held for three cycles with no grants.
        do_cycle(3'b001, 1'b0, 1'b1, 3'b001);
        repeat (3) do_cycle(3'b111, 1'b0, 1'b0, 3'b000);
        do_cycle(3'b111, 1'b0, 1'b1, 3'b010);
        do_cycle(3'b011, 1'b0, 1'b1, 3'b001);
        // Flush during a stall still squashes and rewinds the pointer to 0.
        do_cycle(3'b111, 1'b1, 1'b0, 3'b000);
        do_cycle(3'b111, 1'b0, 1'b1, 3'b001);

        // Async reset between edges while a broadcast is live.
        do_cycle(3'b110, 1'b0, 1'b1, 3'b010);
        #2;
        rst_in = 1'b0;
        #1;
        m_valid = 1'b0;
        m_robid = '0;
        m_value = '0;
        m_taken = 1'b0;
        sb_q.delete();
        chk("midreset_req_ready", 32'(req_ready), 32'h0);
        chk_cdb();
        req_valid = 3'b000;
        @(negedge clk_in);
        rst_in = 1'b1;
        do_cycle(3'b110, 1'b0, 1'b1, 3'b010);
        do_cycle(3'b000, 1'b0, 1'b1, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Arbitrates result writeback from NREQ execution units (ALU, LSB, branch unit, ...) onto the single common data bus (CDB). The CDB feeds the reorder buffer value/busy update and the reservation-station wakeup. Round-robin, one grant per cycle, registered broadcast. A flush input squashes all in-flight results on a branch mispredict.

Parameters:
NREQ, 3, number of requesting execution units (2..8)
ROB_BITS, 4, width of a reorder buffer index
PTR_W, 3, width of round-robin pointer; must satisfy 2^PTR_W >= NREQ

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous active-low reset
rdy_in  input  1  global ready; CPU paused when low
flush  input  1  mispredict squash, from the reorder buffer commit path
req_valid  input  NREQ  requester i holds a result
req_robid  input  NREQ*ROB_BITS  packed ROB index; slice i belongs to requester i
req_value  input  NREQ*32  packed result value (pc+4 for jumps, resolved target for branches)
req_taken  input  NREQ  actual branch outcome; don't-care for non-branches
req_ready  output  NREQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i]
cdb_valid  output  1  broadcast valid
cdb_robid  output  ROB_BITS  broadcast ROB index
cdb_value  output  32  broadcast value
cdb_taken  output  1  broadcast branch outcome

Behaviour:
- Reset (rst_in low, asynchronous): cdb_valid=0, cdb_robid=0, cdb_value=0, cdb_taken=0, rr_ptr=0. req_ready is combinational and is 0 while reset is asserted.
- req_ready is combinational from req_valid, rr_ptr, rdy_in and flush. It is at most one-hot.
- A requester keeps req_valid and its data stable until it samples req_ready=1. It may deassert req_valid only after the transfer.
- Grant search starts at index rr_ptr, goes upward, and wraps at NREQ-1 -> 0. The first i with req_valid[i]=1 is granted.
- After a grant to i: rr_ptr <= (i==NREQ-1) ? 0 : i+1. With no grant, rr_ptr is unchanged.
- Latency: the grant in cycle N drives cdb_* valid in cycle N+1, held exactly 1 cycle. Throughput is 1 result per cycle.
- Idle: when no request is pending, the next cycle has cdb_valid=0. cdb_robid, cdb_value and cdb_taken hold their last values.
- flush=1: req_ready=0 for all requesters, cdb_valid<=0 next cycle, rr_ptr<=0. Requesters drop their own state on flush. flush overrides everything except reset.
- rdy_in=0: req_ready=0, and all registers hold, including cdb_valid. The ROB is also stalled, so the broadcast re-presents without loss. flush takes effect even when rdy_in=0.
- Reset mid-transfer: outputs clear immediately. No partial broadcast survives.
- NREQ=1 degenerates to a registered pass-through. rr_ptr stays 0.

Optional Feature:
CDB_STATS_EN
- Defined: adds outputs stat_grants (NREQ*16, a per-requester saturating grant counter) and stat_conflict (16, a saturating count of cycles with more than one req_valid and rdy_in=1).
  - Both counters clear on reset and do not clear on flush.
  - Counters saturate at 16'hFFFF.
- Undefined: the ports and counters are absent. Arbitration behaviour is identical.

Test Plan:
- Single requester: req_valid=3'b010, robid=5, value=32'h1000 -> req_ready=3'b010 the same cycle; next cycle cdb_valid=1, robid=5, value=32'h1000; the following cycle cdb_valid=0.
- Round-robin: all three requesters valid continuously from reset -> grant order 0,1,2,0,1,2, cdb_valid high every cycle, robids in matching order.
- Wrap: rr_ptr=2, req_valid=3'b011 -> grant 0, then rr_ptr=1.
- Flush: grant issued in cycle N, flush=1 in cycle N+1 with req_valid=3'b111 -> req_ready=0 in N+1; cdb_valid=0 in N+2; the first grant after flush goes to requester 0.
- rdy_in low: cdb_valid=1 with robid=7, then rdy_in=0 for 3 cycles -> cdb_* unchanged, req_ready=0; the first cycle after rdy_in=1 behaves normally.
- Async reset mid-stream: rst_in falls between clock edges while cdb_valid=1 -> cdb_valid=0 immediately; after release, the first grant goes to the lowest valid index.
